// File: rtl/seq_timer.sv
// Programmable down-counter for one sequencer output slot: prescaled ticks,
// one-shot or periodic expiry, sticky flags and a selectable readback byte.
module seq_timer #(
  parameter int PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] oreg,
  input  logic        oreg_wen,
  output logic [7:0]  ireg,
  output logic        expired
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_LDL   = 4'h1;
  localparam logic [3:0] CMD_START = 4'h2;
  localparam logic [3:0] CMD_STOP  = 4'h3;
  localparam logic [3:0] CMD_CLR   = 4'h4;
  localparam logic [3:0] CMD_SEL   = 4'h5;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic        periodic_q, periodic_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  reload_q, reload_d;
  logic [7:0]  presc_q, presc_d;
  logic        exp_q, exp_d;
  logic        err_q, err_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  ireg_q, ireg_d;
  logic        expired_q, expired_d;

  logic [3:0]  cmd;
  logic [7:0]  data;
  logic        is_run;
  logic        start_stop;
  logic        tick;

  assign cmd        = oreg[11:8];
  assign data       = oreg[7:0];
  assign is_run     = (state_q == RUN);
  assign start_stop = oreg_wen && ((cmd == CMD_START) || (cmd == CMD_STOP));
  // A START/STOP on the tick edge swallows the tick entirely.
  assign tick       = is_run && (presc_q == PRESC_LAST) && !start_stop;

  always_comb begin
    state_d    = state_q;
    periodic_d = periodic_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    presc_d    = presc_q;
    exp_d      = exp_q;
    err_d      = err_q;
    ecnt_d     = ecnt_q;
    sel_d      = sel_q;
    expired_d  = 1'b0;

    if (oreg_wen) begin
      case (cmd)
        CMD_NOP: ;
        CMD_LDL: reload_d = data;
        CMD_START: begin
          cnt_d      = reload_q;
          presc_d    = 8'd0;
          periodic_d = data[0];
          state_d    = RUN;
        end
        CMD_STOP: state_d = IDLE;
        CMD_CLR: begin
          exp_d  = 1'b0;
          err_d  = 1'b0;
          ecnt_d = 8'd0;
        end
        CMD_SEL: sel_d = data[1:0];
        default: err_d = 1'b1;
      endcase
    end

    // Counting runs after command decode so an expiry overrides a CLR and
    // a periodic reload sees a same-edge LDL.
    if (is_run && !start_stop) begin
      if (tick) begin
        presc_d = 8'd0;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          expired_d = 1'b1;
          exp_d     = 1'b1;
          ecnt_d    = ecnt_d + 8'd1;
          if (periodic_q) cnt_d = reload_d;
          else            state_d = IDLE;
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    case (sel_q)
      2'd0:    ireg_d = cnt_q;
      2'd1:    ireg_d = {is_run, periodic_q, 4'b0000, err_q, exp_q};
      2'd2:    ireg_d = reload_q;
      default: ireg_d = ecnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      periodic_q <= 1'b0;
      cnt_q      <= 8'd0;
      reload_q   <= 8'd0;
      presc_q    <= 8'd0;
      exp_q      <= 1'b0;
      err_q      <= 1'b0;
      ecnt_q     <= 8'd0;
      sel_q      <= 2'd0;
      ireg_q     <= 8'd0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      periodic_q <= periodic_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      presc_q    <= presc_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      ecnt_q     <= ecnt_d;
      sel_q      <= sel_d;
      ireg_q     <= ireg_d;
      expired_q  <= expired_d;
    end
  end

  assign ireg    = ireg_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_seq_timer.sv
// Bench for seq_timer: PRESCALE=4 and PRESCALE=1 instances share stimulus and
// are compared every cycle against a procedural model of the command rules.
module tb_seq_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] oreg = 12'h000;
  logic        oreg_wen = 1'b0;
  logic [7:0]  ireg_a, ireg_b;
  logic        exp_a, exp_b;

  int n_chk = 0;
  int n_pass = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clock = ~clock;

  seq_timer #(.PRESCALE(4)) u_p4 (
    .clock(clock), .reset(reset), .oreg(oreg), .oreg_wen(oreg_wen),
    .ireg(ireg_a), .expired(exp_a)
  );

  seq_timer #(.PRESCALE(1)) u_p1 (
    .clock(clock), .reset(reset), .oreg(oreg), .oreg_wen(oreg_wen),
    .ireg(ireg_b), .expired(exp_b)
  );

  // Reference state, index 0 = PRESCALE 4, index 1 = PRESCALE 1.
  int PSC[2] = '{4, 1};
  int m_run[2], m_per[2], m_cnt[2], m_rel[2], m_presc[2];
  int m_exp[2], m_err[2], m_ecnt[2], m_sel[2], m_ireg[2], m_pulse[2];

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_per[i] = 0; m_cnt[i] = 0; m_rel[i] = 0; m_presc[i] = 0;
      m_exp[i] = 0; m_err[i] = 0; m_ecnt[i] = 0; m_sel[i] = 0;
      m_ireg[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_edge(input bit wen, input int cmd, input int d);
    for (int i = 0; i < 2; i++) begin
      int was_run, is_tick, swallowed, rb;
      was_run   = m_run[i];
      is_tick   = (m_presc[i] == PSC[i] - 1);
      swallowed = 0;
      case (m_sel[i])
        0: rb = m_cnt[i];
        1: rb = (m_run[i] << 7) | (m_per[i] << 6) | (m_err[i] << 1) | m_exp[i];
        2: rb = m_rel[i];
        default: rb = m_ecnt[i];
      endcase
      m_pulse[i] = 0;
      if (wen) begin
        if (cmd == 1) m_rel[i] = d;
        else if (cmd == 2) begin
          m_cnt[i] = m_rel[i]; m_presc[i] = 0; m_per[i] = d & 1; m_run[i] = 1; swallowed = 1;
        end else if (cmd == 3) begin
          m_run[i] = 0; swallowed = 1;
        end else if (cmd == 4) begin
          m_exp[i] = 0; m_err[i] = 0; m_ecnt[i] = 0;
        end else if (cmd == 5) m_sel[i] = d & 3;
        else if (cmd >= 6) m_err[i] = 1;
      end
      if (was_run && !swallowed) begin
        if (is_tick) begin
          m_presc[i] = 0;
          if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            m_pulse[i] = 1;
            m_exp[i] = 1;
            m_ecnt[i] = (m_ecnt[i] + 1) % 256;
            if (m_per[i]) m_cnt[i] = m_rel[i];
            else m_run[i] = 0;
          end
        end else m_presc[i] = m_presc[i] + 1;
      end
      m_ireg[i] = rb;
    end
  endtask

  task automatic compare_all();
    check("p4_ireg", ireg_a, m_ireg[0]);
    check("p4_expired", exp_a, m_pulse[0]);
    check("p1_ireg", ireg_b, m_ireg[1]);
    check("p1_expired", exp_b, m_pulse[1]);
  endtask

  task automatic cyc(input bit wen, input logic [3:0] cmd, input logic [7:0] d);
    oreg_wen = wen;
    oreg = {cmd, d};
    @(posedge clock);
    model_edge(wen, int'(cmd), int'(d));
    #1;
    compare_all();
    if (exp_a) pulses_a++;
    if (exp_b) pulses_b++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 4'h0, 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_p4_ireg", ireg_a, 0);
    check("rst_p4_expired", exp_a, 0);
    check("rst_p1_ireg", ireg_b, 0);
    check("rst_p1_expired", exp_b, 0);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      compare_all();
    end
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b1;

    // One-shot count
    cyc(1, 4'h1, 8'h03);
    cyc(1, 4'h5, 8'h00);
    cyc(1, 4'h2, 8'h00);
    pulses_a = 0;
    idle(17);
    check("oneshot_pulses", pulses_a, 1);
    cyc(1, 4'h5, 8'h01);
    idle(1);
    check("oneshot_status", ireg_a, 8'h01);

    // Periodic count
    cyc(1, 4'h4, 8'h00);
    cyc(1, 4'h1, 8'h01);
    cyc(1, 4'h2, 8'h01);
    pulses_a = 0;
    idle(24);
    check("periodic_pulses", pulses_a, 3);
    cyc(1, 4'h5, 8'h03);
    idle(1);
    check("periodic_ecnt", ireg_a, 8'h03);
    cyc(1, 4'h3, 8'h00);
    pulses_a = 0;
    idle(20);
    check("stop_no_pulse", pulses_a, 0);

    // Strobe gating and bad command
    do_reset(1);
    cyc(0, 4'h1, 8'hBE);
    cyc(1, 4'h5, 8'h02);
    idle(1);
    check("nowen_reload", ireg_a, 8'h00);
    cyc(1, 4'h5, 8'h01);
    cyc(1, 4'hF, 8'h00);
    idle(1);
    check("bad_cmd_status", ireg_a, 8'h02);
    cyc(1, 4'h4, 8'h00);
    idle(1);
    check("clr_status", ireg_a, 8'h00);

    // CLR landing on an expiry edge
    cyc(1, 4'h1, 8'h01);
    cyc(1, 4'h2, 8'h00);
    idle(7);
    cyc(1, 4'h4, 8'h00);
    check("clr_expiry_pulse", exp_a, 1);
    idle(1);
    check("clr_expiry_status", ireg_a, 8'h01);
    cyc(1, 4'h5, 8'h03);
    idle(1);
    check("clr_expiry_ecnt", ireg_a, 8'h01);

    // START landing on an expiry edge
    cyc(1, 4'h5, 8'h00);
    cyc(1, 4'h1, 8'h02);
    cyc(1, 4'h2, 8'h01);
    idle(11);
    cyc(1, 4'h2, 8'h01);
    check("start_expiry_nopulse", exp_a, 0);
    idle(1);
    check("start_expiry_cnt", ireg_a, 8'h02);
    cyc(1, 4'h3, 8'h00);

    // Reset mid-run
    cyc(1, 4'h1, 8'h05);
    cyc(1, 4'h2, 8'h00);
    idle(6);
    do_reset(2);
    pulses_a = 0;
    pulses_b = 0;
    idle(40);
    check("post_reset_p4_pulses", pulses_a, 0);
    check("post_reset_p1_pulses", pulses_b, 0);

    // Expiry-count wrap at PRESCALE 1
    cyc(1, 4'h4, 8'h00);
    cyc(1, 4'h5, 8'h03);
    cyc(1, 4'h1, 8'h00);
    cyc(1, 4'h2, 8'h01);
    pulses_b = 0;
    idle(256);
    check("wrap_pulses", pulses_b, 256);
    idle(1);
    check("wrap_ecnt", ireg_b, 8'h00);
    cyc(1, 4'h3, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] c;
      logic [7:0] d;
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 2));
        continue;
      end
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      if (r < 15) begin c = 4'h1; d = 8'($urandom_range(0, 6)); end
      else if (r < 30) c = 4'h2;
      else if (r < 38) c = 4'h3;
      else if (r < 48) c = 4'h4;
      else if (r < 70) c = 4'h5;
      else if (r < 80) c = 4'h0;
      else c = 4'($urandom_range(6, 15));
      cyc($urandom_range(0, 5) == 0, c, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_timer.md
# seq_timer

Programmable down-counter peripheral driven by the `Seq` sequencer's output-register bus. One `seq_timer` occupies one sequencer output slot. It takes its `oreg` command word when that slot's `oreg_wen` bit is high, and returns one byte on one sequencer `ireg_N` input. The sequencer uses it for delays, polling loops (`JZ`/`JN` on the readback), and periodic events.

## Interface

Parameters:
- `PRESCALE`, default 4: clock cycles per count tick. Legal values are 1 to 255.

Ports:
- `clock`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low. `reset == 0` clears all state immediately.
- `oreg`  in  12: command word `{cmd[3:0], data[7:0]}` from the sequencer.
- `oreg_wen`  in  1: this slot's write strobe, one bit of the sequencer's `oreg_wen`. `oreg` is ignored (may be X) when it is low.
- `ireg`  out  8: registered readback byte, wired to a sequencer `ireg_N`.
- `expired`  out  1: registered one-cycle pulse on each expiry.

## Operation

Internal state:
- `run` (state IDLE/RUN)
- `periodic`
- `cnt[7:0]`, `reload[7:0]`
- `presc` (0..PRESCALE-1)
- `exp`, sticky expiry flag
- `err`, sticky bad-command flag
- `ecnt[7:0]`, expiry count, wraps 0xFF->0x00
- `sel[1:0]`

Commands, acted on only at an edge where `oreg_wen == 1`:
- 0x0 NOP: no effect.
- 0x1 LDL: `reload = data`. `cnt` and the state are unchanged.
- 0x2 START: `cnt = reload`, `presc = 0`, `periodic = data[0]`, state RUN. START while already in RUN restarts the count.
- 0x3 STOP: state IDLE. `cnt` and `presc` hold their values.
- 0x4 CLR: `exp = 0`, `err = 0`, `ecnt = 0`.
- 0x5 SEL: `sel = data[1:0]`. `data[7:2]` is ignored.
- 0x6 to 0xF: `err = 1`; nothing else changes.

Counting, in RUN only:
- `presc` increments every cycle.
- A tick occurs on the edge where `presc == PRESCALE-1`; `presc` then returns to 0.
- On a tick with `cnt != 0`: `cnt -= 1`.
- On a tick with `cnt == 0` (expiry): `expired` pulses, `exp = 1`, `ecnt += 1`. Then:
  - periodic: `cnt = reload` and RUN continues;
  - one-shot: state goes to IDLE and `cnt` stays 0.
- IDLE: `presc` and `cnt` hold.

Readback source by `sel`:
- 0: `cnt`
- 1: status `{run, periodic, 4'b0000, err, exp}`
- 2: `reload`
- 3: `ecnt`

Simultaneous events at one edge:
- START or STOP with a tick: the tick is discarded. No pulse, no decrement, no flag update.
- CLR with an expiry: set wins. `exp = 1`, `ecnt = 1`, `err = 0`, and `expired` pulses.
- LDL, SEL, NOP or a bad command with a tick: the tick proceeds normally. For LDL, a periodic reload uses the new `reload` value.

## Timing

- Reset values:
  - `ireg = 0x00`, `expired = 0`
  - state IDLE, `periodic = 0`
  - `cnt`, `reload`, `presc`, `ecnt`, `sel` all 0
  - `exp = err = 0`
- Reset asserted mid-run aborts immediately, with no pending pulse. Counting resumes only after a new START.
- Command latency: state is updated at the edge where `oreg_wen` is sampled high.
- `ireg` is a register loaded every edge from the selected source's pre-edge value, so it lags internal state by one cycle. A command's effect is visible on `ireg` two edges after it is sampled.
- Period: START sampled at edge T with `reload = R` gives the first expiry at edge T + (R+1)·PRESCALE. Periodic mode then expires every (R+1)·PRESCALE cycles.
- `expired` is high for exactly the cycle after the expiry edge.
- With `PRESCALE == 1`, every RUN cycle is a tick.

## Test plan

- One-shot count, PRESCALE=4:
  - stimulus: LDL 0x03, SEL 0x00, START 0x00 at edge T;
  - `cnt` steps 3, 2, 1, 0 at T+4, T+8, T+12;
  - `expired` pulses once, after edge T+16;
  - SEL 0x01 then reads 0x01 (IDLE, exp set).
- Periodic count:
  - stimulus: LDL 0x01, START 0x01;
  - `expired` pulses every 8 cycles;
  - after 3 pulses, SEL 0x03 reads 0x03;
  - STOP freezes `cnt` and no further pulses occur.
- Strobe and errors:
  - `{0x1, 0xBE}` with `oreg_wen = 0` leaves `reload` at 0x00;
  - command 0xF with `oreg_wen = 1` makes status read 0x02;
  - CLR returns status to 0x00.
- Coincidence:
  - CLR on an expiry edge: status shows exp=1 and `ecnt` reads 0x01;
  - START on an expiry edge: no pulse, and `cnt` reads `reload`.
- Reset mid-run: drive `reset = 0` for 2 cycles during RUN. `ireg` and `expired` go to 0 at once, and no expiry occurs after release.
- Wrap at PRESCALE=1: LDL 0x00, START 0x01. After 256 expiries, `ecnt` reads 0x00 and `expired` has pulsed on every cycle.
